// File: rtl/oc8051_memguard.sv
`default_nettype none
// ============================================================================
//  Module   : oc8051_memguard
//  Purpose  : Privilege-checking memory port stage behind the two-core
//             arbiter. Permitted requests go to a wait-stated memory port.
//             Denied requests end locally with ack, viol and sticky logging.
//  Option   : OC8051_MEMGUARD_TIMEOUT_EN enables a WAIT-state timeout.
//             A timed-out request completes with err=1 and data_out=8'hFF.
//  Revision : 1.0  initial release
// ============================================================================
module oc8051_memguard #(
    parameter logic [15:0] PROT_BASE = 16'hF000,
    parameter logic [15:0] PROT_TOP  = 16'hFFFF,
    parameter logic [15:0] CODE_TOP  = 16'h0FFF,
    parameter int          TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stb,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [7:0]  data_in,
    input  logic        priv_lvl,
    input  logic [15:0] dpc_ot,
    output logic        ack,
    output logic [7:0]  data_out,
    output logic        mem_cs,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_rdy,
    output logic        viol,
    output logic [15:0] viol_addr,
    output logic [15:0] viol_pc,
    output logic [7:0]  viol_cnt,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_ack, w_ack;
    logic        r_viol, w_viol;
    logic        r_err, w_err;
    logic        r_mem_cs, w_mem_cs;
    logic        r_mem_we, w_mem_we;
    logic [15:0] r_mem_addr, w_mem_addr;
    logic [7:0]  r_mem_wdata, w_mem_wdata;
    logic [7:0]  r_dout, w_dout;
    logic [15:0] r_vaddr, w_vaddr;
    logic [15:0] r_vpc, w_vpc;
    logic [7:0]  r_vcnt, w_vcnt;
    logic        w_deny;
    logic        w_timeout;

    // Protection rules evaluated on the live request while in IDLE.
    assign w_deny = !priv_lvl &&
                    (((addr >= PROT_BASE) && (addr <= PROT_TOP)) ||
                     (wr && (addr <= CODE_TOP)));

`ifdef OC8051_MEMGUARD_TIMEOUT_EN
    localparam logic [7:0] c_wait_limit = 8'(TIMEOUT - 1);
    logic [7:0] r_wcnt;

    // WAIT-cycle counter; held at zero outside WAIT so it is clear on entry.
    always_ff @(posedge clk) begin
        if (rst || (r_state != S_WAIT)) begin
            r_wcnt <= 8'd0;
        end else begin
            r_wcnt <= r_wcnt + 8'd1;
        end
    end

    assign w_timeout = (r_wcnt == c_wait_limit);
`else
    assign w_timeout = 1'b0;
`endif

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ack       <= 1'b0;
            r_viol      <= 1'b0;
            r_err       <= 1'b0;
            r_mem_cs    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 16'h0000;
            r_mem_wdata <= 8'h00;
            r_dout      <= 8'h00;
            r_vaddr     <= 16'h0000;
            r_vpc       <= 16'h0000;
            r_vcnt      <= 8'h00;
        end else begin
            r_state     <= w_state_nxt;
            r_ack       <= w_ack;
            r_viol      <= w_viol;
            r_err       <= w_err;
            r_mem_cs    <= w_mem_cs;
            r_mem_we    <= w_mem_we;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_dout      <= w_dout;
            r_vaddr     <= w_vaddr;
            r_vpc       <= w_vpc;
            r_vcnt      <= w_vcnt;
        end
    end

    // Next-state and next-output decode; pulses default low, data holds.
    always_comb begin
        w_state_nxt = r_state;
        w_ack       = 1'b0;
        w_viol      = 1'b0;
        w_err       = 1'b0;
        w_mem_cs    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        w_dout      = r_dout;
        w_vaddr     = r_vaddr;
        w_vpc       = r_vpc;
        w_vcnt      = r_vcnt;
        case (r_state)
            S_IDLE: begin
                if (stb) begin
                    w_mem_addr  = addr;
                    w_mem_wdata = data_in;
                    if (w_deny) begin
                        w_state_nxt = S_ACK;
                        w_ack       = 1'b1;
                        w_viol      = 1'b1;
                        w_dout      = 8'hFF;
                        w_vaddr     = addr;
                        w_vpc       = dpc_ot;
                        w_vcnt      = (r_vcnt == 8'hFF) ? r_vcnt : r_vcnt + 8'd1;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_mem_cs    = 1'b1;
                        w_mem_we    = wr;
                    end
                end
            end
            S_WAIT: begin
                if (mem_rdy) begin
                    // Ready wins over a timeout reached in the same cycle.
                    w_state_nxt = S_ACK;
                    w_ack       = 1'b1;
                    if (!r_mem_we) begin
                        w_dout = mem_rdata;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = S_ACK;
                    w_ack       = 1'b1;
                    w_err       = 1'b1;
                    w_dout      = 8'hFF;
                end else begin
                    w_mem_cs = 1'b1;
                    w_mem_we = r_mem_we;
                end
            end
            S_ACK: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign ack       = r_ack;
    assign data_out  = r_dout;
    assign mem_cs    = r_mem_cs;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign viol      = r_viol;
    assign viol_addr = r_vaddr;
    assign viol_pc   = r_vpc;
    assign viol_cnt  = r_vcnt;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: doc/oc8051_memguard.md
# oc8051_memguard

Privilege-checking memory port stage placed directly downstream of the two-core processor arbiter. It consumes the arbiter's selected request (stb/wr/addr/data_in/priv_lvl/dpc_ot) and checks it against two fixed protection rules. Permitted requests are forwarded to a wait-stated memory port. Denied requests, and optionally timed-out ones, are terminated locally with a one-cycle `ack` and violation reporting.

## Interface
Parameters:
- PROT_BASE, 16'hF000, lowest address of the privileged window.
- PROT_TOP, 16'hFFFF, highest address of the privileged window (inclusive).
- CODE_TOP, 16'h0FFF, highest address of the write-protected code region (inclusive).
- TIMEOUT, 16, maximum WAIT cycles; used only with the timeout macro; legal range 1..255.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- stb  in  1  request from arbiter; held until `ack`.
- wr  in  1  1 = write, 0 = read.
- addr  in  16  request address.
- data_in  in  8  write data.
- priv_lvl  in  1  1 = privileged requester.
- dpc_ot  in  16  requester PC, used for violation logging.
- ack  out  1  one-cycle completion pulse to arbiter.
- data_out  out  8  read data; valid in the `ack` cycle.
- mem_cs  out  1  memory select; held through WAIT.
- mem_we  out  1  memory write enable.
- mem_addr  out  16  latched address.
- mem_wdata  out  8  latched write data.
- mem_rdata  in  8  memory read data; sampled when `mem_rdy`=1.
- mem_rdy  in  1  memory ready; qualifies completion in WAIT.
- viol  out  1  one-cycle pulse coincident with `ack` of a denied request.
- viol_addr  out  16  address of the most recent violation (sticky).
- viol_pc  out  16  `dpc_ot` of the most recent violation (sticky).
- viol_cnt  out  8  saturating violation count.
- err  out  1  one-cycle pulse coincident with `ack` of a timed-out request.

## Operation
- States: IDLE, WAIT, ACK.
- IDLE, `stb`=1: latch wr/addr/data_in/priv_lvl/dpc_ot into request registers, then evaluate the rules.
  - Deny if `priv_lvl`=0 and PROT_BASE<=addr<=PROT_TOP.
  - Deny if `priv_lvl`=0, wr=1 and addr<=CODE_TOP.
  - Denied: go to ACK. No `mem_cs`. `data_out`=8'hFF. On the `ack` cycle: `viol`=1, `viol_addr`/`viol_pc` updated, `viol_cnt` incremented, saturating at 255.
  - Permitted: go to WAIT.
- WAIT:
  - `mem_cs`=1; `mem_we`=latched wr; `mem_addr`/`mem_wdata` come from the latched registers.
  - `mem_rdy`=1: capture `mem_rdata` into `data_out` (reads only; writes leave `data_out` unchanged), then go to ACK.
- ACK:
  - `ack`=1 for exactly one cycle; `mem_cs`=0; next state IDLE.
  - `stb` is ignored in ACK.
- Request inputs are sampled only in IDLE. Changes to them during WAIT/ACK have no effect.
- Back-to-back requests: a new `stb` is accepted in the IDLE cycle right after ACK, including a request from a different core.

## Timing
- Reset values: state IDLE; ack 0, mem_cs 0, mem_we 0, mem_addr 0, mem_wdata 0, data_out 8'h00, viol 0, viol_addr 0, viol_pc 0, viol_cnt 0, err 0.
- Permitted, zero-wait (mem_rdy=1 on the first WAIT cycle):
  - stb sampled in cycle N; mem_cs high in N+1; ack in N+2.
  - Each additional low-`mem_rdy` cycle adds one cycle.
- Denied: stb sampled in N; ack and viol in N+1.
- All outputs are registered; `mem_*` never glitch combinationally from `stb`.
- `rst` during WAIT or ACK: returns to IDLE next cycle, drops `mem_cs`, issues no ack. The sticky viol_* registers are also cleared.
- `viol_cnt` at 255 stays at 255 on further violations.

## Configuration
- OC8051_MEMGUARD_TIMEOUT_EN defined:
  - An 8-bit WAIT counter is cleared on entry to WAIT.
  - If `mem_rdy` is still 0 after TIMEOUT WAIT cycles, go to ACK with `data_out`=8'hFF and `err`=1; `mem_cs` drops.
  - `mem_rdy` in the same cycle the limit is reached takes priority: normal completion, no `err`.
- Not defined: WAIT lasts until `mem_rdy`; `err` is tied to 0 and no counter is built.

## Test plan
- Priv 0 read, addr 16'h2000, mem_rdy=1, mem_rdata=8'hA5 -> mem_cs high one cycle, ack 2 cycles after stb, data_out=8'hA5, viol=0.
- Priv 0 write, addr 16'h0100 -> ack 1 cycle after stb, mem_cs never high, viol=1, viol_addr=16'h0100, viol_pc=dpc_ot, viol_cnt=1.
- Priv 1 read, addr 16'hF800, mem_rdy delayed 3 cycles -> mem_cs high 4 cycles, ack on cycle 5, correct data; priv 0 to the same address -> data_out=8'hFF, viol=1.
- 256 denied requests -> viol_cnt=255; rst asserted while in WAIT -> no ack, mem_cs=0 next cycle, viol_cnt=0.
- Two requests back-to-back (addr 16'h1234 then 16'h5678) -> second stb accepted in the IDLE cycle after the first ack; mem_addr follows each request; exactly two ack pulses.
- TIMEOUT_EN, TIMEOUT=4, mem_rdy stuck low -> ack after 4 WAIT cycles, err=1, data_out=8'hFF; mem_rdy rising on the 4th cycle -> normal completion, err=0.
